// File: rtl/roic_pkg.sv
// Shared types and helpers for the ROIC pixel capture slice.
// Holds the array geometry, the capture FSM state encoding, the FIFO entry
// payload, and the one-hot select decoder used by the capture front end.
package roic_pkg;

  localparam int unsigned ROIC_ROWS   = 2;
  localparam int unsigned ROIC_COLS   = 10;
  localparam int unsigned ROIC_DATA_W = 12;
  localparam int unsigned ROIC_ROW_W  = (ROIC_ROWS > 1) ? $clog2(ROIC_ROWS) : 1;
  localparam int unsigned ROIC_COL_W  = (ROIC_COLS > 1) ? $clog2(ROIC_COLS) : 1;

  // Encoder scan width; row/column enables are zero-extended to this.
  localparam int unsigned SCAN_W = 16;

  typedef enum logic [2:0] {
    CAP_IDLE      = 3'd0,
    CAP_SETTLE    = 3'd1,
    CAP_CONVERT   = 3'd2,
    CAP_WAIT_DONE = 3'd3,
    CAP_STORE     = 3'd4
  } cap_state_e;

  typedef struct packed {
    logic [ROIC_DATA_W-1:0] data;
    logic [ROIC_ROW_W-1:0]  row;
    logic [ROIC_COL_W-1:0]  col;
    logic                   sof;
    logic                   eof;
  } pix_entry_t;

  typedef struct packed {
    logic                  valid;  // both enables exactly one-hot
    logic                  err;    // neither legal nor idle
    logic [ROIC_ROW_W-1:0] row;
    logic [ROIC_COL_W-1:0] col;
  } sel_t;

  function automatic logic onehot_scan(input logic [SCAN_W-1:0] v);
    return (v != '0) && ((v & (v - SCAN_W'(1))) == '0);
  endfunction

  function automatic logic [3:0] encode_scan(input logic [SCAN_W-1:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < int'(SCAN_W); i++) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  // Both-zero is idle; anything else that is not a clean one-hot pair is an error.
  function automatic sel_t decode_sel(input logic [ROIC_ROWS-1:0] r,
                                      input logic [ROIC_COLS-1:0] c);
    sel_t s;
    logic r_oh;
    logic c_oh;
    logic idle;
    r_oh    = onehot_scan(SCAN_W'(r));
    c_oh    = onehot_scan(SCAN_W'(c));
    idle    = (r == '0) && (c == '0);
    s.valid = r_oh && c_oh;
    s.err   = !(r_oh && c_oh) && !idle;
    s.row   = ROIC_ROW_W'(encode_scan(SCAN_W'(r)));
    s.col   = ROIC_COL_W'(encode_scan(SCAN_W'(c)));
    return s;
  endfunction

endpackage

// File: rtl/roic_capture_fifo.sv
// Synchronous FIFO of pix_entry_t with a registered head.
// The head register counts toward DEPTH, so at most DEPTH entries are held.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   push, push_entry  write request and payload (ignored when full without pop)
//   pop               consumer ready; only effective while head_valid
//   head_valid, head  registered stream head
//   full_c            combinational: DEPTH entries held
module roic_capture_fifo
  import roic_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  pix_entry_t push_entry,
  input  logic       pop,
  output logic       head_valid,
  output pix_entry_t head,
  output logic       full_c
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  pix_entry_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] mem_cnt_q;
  logic [CNT_W-1:0] total_c;
  logic             pop_ok_c;
  logic             push_ok_c;
  logic             load_c;

  // Occupancy includes the head register.
  assign total_c   = mem_cnt_q + CNT_W'(head_valid);
  assign full_c    = (total_c == CNT_W'(DEPTH));
  assign pop_ok_c  = pop && head_valid;
  assign push_ok_c = push && (!full_c || pop_ok_c);
  // Head refills from storage when empty or being consumed.
  assign load_c    = (!head_valid || pop_ok_c) && (mem_cnt_q != '0);

  // Storage array, no reset needed: occupancy is tracked by the counters.
  always_ff @(posedge clk) begin
    if (push_ok_c) mem[wr_ptr_q] <= push_entry;
  end

  // Pointers, occupancy and the registered head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      mem_cnt_q  <= '0;
      head_valid <= 1'b0;
      head       <= '0;
    end else begin
      if (push_ok_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (load_c)    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      mem_cnt_q <= mem_cnt_q + CNT_W'(push_ok_c) - CNT_W'(load_c);
      if (load_c) begin
        head       <= mem[rd_ptr_q];
        head_valid <= 1'b1;
      end else if (pop_ok_c) begin
        head_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/roic_pixel_capture.sv
// Pixel capture stage behind the ROIC row/column traversal FSM.
// Detects each newly selected pixel, waits the analog settle time, runs one
// ADC handshake, tags the sample with address and frame flags, and queues it
// on a valid/ready stream.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   row_enable, col_enable      one-hot pixel select
//   adc_start / adc_done, adc_data   conversion handshake
//   pix_valid/pix_ready, pix_data/row/col/sof/eof   output stream
//   overflow, sel_err           sticky status, cleared by reset only
module roic_pixel_capture
  import roic_pkg::*;
#(
  parameter int unsigned NUM_ROWS   = ROIC_ROWS,
  parameter int unsigned NUM_COLS   = ROIC_COLS,
  parameter int unsigned DATA_W     = ROIC_DATA_W,
  parameter int unsigned SETTLE     = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_ROWS-1:0]   row_enable,
  input  logic [NUM_COLS-1:0]   col_enable,
  output logic                  adc_start,
  input  logic                  adc_done,
  input  logic [DATA_W-1:0]     adc_data,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic [DATA_W-1:0]     pix_data,
  output logic [ROIC_ROW_W-1:0] pix_row,
  output logic [ROIC_COL_W-1:0] pix_col,
  output logic                  pix_sof,
  output logic                  pix_eof,
  output logic                  overflow,
  output logic                  sel_err
);

  localparam int unsigned CNT_W = 8;

  cap_state_e            state_q;
  cap_state_e            state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cnt_d;
  sel_t                  sel_c;
  logic [ROIC_ROW_W-1:0] row_q;
  logic [ROIC_COL_W-1:0] col_q;
  logic [ROIC_ROW_W-1:0] last_row_q;
  logic [ROIC_COL_W-1:0] last_col_q;
  logic                  last_none_q;
  logic                  prev_valid_q;
  logic [DATA_W-1:0]     data_q;
  logic                  trig_c;
  logic                  same_addr_c;
  logic                  push_c;
  logic                  pop_c;
  logic                  fifo_full_c;
  pix_entry_t            push_entry_c;
  pix_entry_t            head;

  assign sel_c       = decode_sel(row_enable, col_enable);
  assign same_addr_c = (sel_c.row == row_q) && (sel_c.col == col_q);
  // New pixel: different from the last stored address, or re-selected after a gap.
  assign trig_c      = sel_c.valid &&
                       (!prev_valid_q || last_none_q ||
                        (sel_c.row != last_row_q) || (sel_c.col != last_col_q));

  // Capture FSM next state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CAP_IDLE: begin
        if (trig_c) begin
          state_d = CAP_SETTLE;
          cnt_d   = '0;
        end
      end
      CAP_SETTLE: begin
        if (!sel_c.valid || !same_addr_c) begin
          state_d = CAP_IDLE;
        end else if (cnt_q == CNT_W'(SETTLE - 1)) begin
          state_d = CAP_CONVERT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      CAP_CONVERT:   state_d = CAP_WAIT_DONE;
      CAP_WAIT_DONE: if (adc_done) state_d = CAP_STORE;
      CAP_STORE:     state_d = CAP_IDLE;
      default:       state_d = CAP_IDLE;
    endcase
  end

  // State, datapath latches and sticky status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= CAP_IDLE;
      cnt_q        <= '0;
      adc_start    <= 1'b0;
      row_q        <= '0;
      col_q        <= '0;
      last_row_q   <= '0;
      last_col_q   <= '0;
      last_none_q  <= 1'b1;
      prev_valid_q <= 1'b0;
      data_q       <= '0;
      overflow     <= 1'b0;
      sel_err      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      adc_start    <= (state_d == CAP_CONVERT);
      prev_valid_q <= sel_c.valid;
      if (state_q == CAP_IDLE && trig_c) begin
        row_q <= sel_c.row;
        col_q <= sel_c.col;
      end
      if (state_q == CAP_WAIT_DONE && adc_done) data_q <= adc_data;
      // A dropped sample still counts as visited so it is not re-captured.
      if (state_q == CAP_STORE) begin
        last_row_q  <= row_q;
        last_col_q  <= col_q;
        last_none_q <= 1'b0;
        if (fifo_full_c && !pop_c) overflow <= 1'b1;
      end
      if (sel_c.err) sel_err <= 1'b1;
    end
  end

  assign push_c = (state_q == CAP_STORE);
  assign pop_c  = pix_valid && pix_ready;

  always_comb begin
    push_entry_c      = '0;
    push_entry_c.data = ROIC_DATA_W'(data_q);
    push_entry_c.row  = row_q;
    push_entry_c.col  = col_q;
    push_entry_c.sof  = (row_q == '0) && (col_q == '0);
    push_entry_c.eof  = (row_q == ROIC_ROW_W'(NUM_ROWS - 1)) &&
                        (col_q == ROIC_COL_W'(NUM_COLS - 1));
  end

  roic_capture_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push_c),
    .push_entry (push_entry_c),
    .pop        (pix_ready),
    .head_valid (pix_valid),
    .head       (head),
    .full_c     (fifo_full_c)
  );

  assign pix_data = DATA_W'(head.data);
  assign pix_row  = head.row;
  assign pix_col  = head.col;
  assign pix_sof  = head.sof;
  assign pix_eof  = head.eof;

endmodule

// File: tb/tb_roic_pixel_capture.sv
// Scoreboard bench for roic_pixel_capture (2x10 array, SETTLE=8, DEPTH=4).
module tb_roic_pixel_capture;

  logic        clk;
  logic        rst_n;
  logic [1:0]  row_enable;
  logic [9:0]  col_enable;
  logic        adc_start;
  logic        adc_done;
  logic [11:0] adc_data;
  logic        pix_valid;
  logic        pix_ready;
  logic [11:0] pix_data;
  logic [0:0]  pix_row;
  logic [3:0]  pix_col;
  logic        pix_sof;
  logic        pix_eof;
  logic        overflow;
  logic        sel_err;

  int          n_chk;
  int          n_pass;
  logic [31:0] exp_q[$];
  int          start_cnt;
  bit          adc_auto;
  int          late_req;
  int          late_seen;
  int          cur_row;
  int          cur_col;

  roic_pixel_capture #(
    .NUM_ROWS(2), .NUM_COLS(10), .DATA_W(12), .SETTLE(8), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .row_enable(row_enable), .col_enable(col_enable),
    .adc_start(adc_start), .adc_done(adc_done), .adc_data(adc_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .pix_row(pix_row), .pix_col(pix_col), .pix_sof(pix_sof), .pix_eof(pix_eof),
    .overflow(overflow), .sel_err(sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] pix_val(input int r, input int c);
    return 12'(1024 + r * 64 + c * 3);
  endfunction

  function automatic logic [31:0] ent(input int r, input int c);
    logic [11:0] d;
    logic        sof;
    logic        eof;
    d   = pix_val(r, c);
    sof = (r == 0) && (c == 0);
    eof = (r == 1) && (c == 9);
    return 32'({d, 1'(r), 4'(c), sof, eof});
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
  endtask

  task automatic set_sel(input int r, input int c);
    row_enable = 2'(1 << r);
    col_enable = 10'(1 << c);
    cur_row    = r;
    cur_col    = c;
  endtask

  task automatic clear_sel();
    row_enable = '0;
    col_enable = '0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, 32'({adc_start, pix_valid, pix_data, pix_row, pix_col,
                     pix_sof, pix_eof, overflow, sel_err}), 32'd0);
  endtask

  // ADC model: done 5 cycles after start; also serves late stray done requests.
  initial begin
    adc_done  = 1'b0;
    adc_data  = '0;
    late_seen = 0;
    forever begin
      @(negedge clk);
      if (late_req != late_seen) begin
        late_seen = late_req;
        adc_done  = 1'b1;
        adc_data  = 12'hFFF;
        @(negedge clk);
        adc_done  = 1'b0;
      end else if (adc_start) begin
        start_cnt++;
        if (adc_auto) begin
          repeat (4) @(negedge clk);
          adc_done = 1'b1;
          adc_data = pix_val(cur_row, cur_col);
          @(negedge clk);
          adc_done = 1'b0;
        end
      end
    end
  end

  // Monitor: pops expected beats on each handshake and checks head stability under stall.
  initial begin
    logic        hold_p;
    logic [31:0] head_p;
    logic [31:0] head_c;
    logic [31:0] e;
    hold_p = 1'b0;
    head_p = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        hold_p = 1'b0;
      end else begin
        head_c = 32'({pix_data, pix_row, pix_col, pix_sof, pix_eof});
        if (hold_p) begin
          check("hold_valid", 32'(pix_valid), 32'd1);
          check("hold_stable", head_c, head_p);
        end
        if (pix_valid && pix_ready) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_beat: got %0h expected no beat", head_c);
          end else begin
            e = exp_q.pop_front();
            check("beat", head_c, e);
          end
        end
        hold_p = pix_valid && !pix_ready;
        head_p = head_c;
      end
    end
  end

  initial begin
    int n;
    int m;
    int s0;
    bit found;
    n_chk = 0; n_pass = 0; start_cnt = 0; late_req = 0;
    adc_auto = 1'b1; cur_row = 0; cur_col = 0;
    rst_n = 1'b0; pix_ready = 1'b1;
    clear_sel();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_outputs");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Latency: trigger -> adc_start, adc_done -> pix_valid.
    set_sel(0, 0);
    exp_q.push_back(ent(0, 0));
    n = 0;
    do begin @(negedge clk); n++; end while (!adc_start && n < 50);
    check("settle_latency", 32'(n), 32'd9);
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      if (adc_done) break;
    end
    m = 0;
    do begin @(negedge clk); m++; end while (!pix_valid && m < 20);
    check("done_to_valid", 32'(m), 32'd3);
    repeat (20) @(negedge clk);
    clear_sel();
    wait_drain("latency_drain");
    repeat (5) @(negedge clk);

    // Frame sweep.
    s0 = start_cnt;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 10; c++) begin
        set_sel(r, c);
        exp_q.push_back(ent(r, c));
        repeat (70) @(negedge clk);
      end
    end
    clear_sel();
    wait_drain("sweep_drain");
    check("sweep_starts", 32'(start_cnt - s0), 32'd20);
    check("sweep_no_overflow", 32'(overflow), 32'd0);

    // Settle abort.
    repeat (5) @(negedge clk);
    s0 = start_cnt;
    set_sel(0, 3);
    repeat (3) @(negedge clk);
    set_sel(0, 4);
    exp_q.push_back(ent(0, 4));
    repeat (40) @(negedge clk);
    clear_sel();
    wait_drain("abort_drain");
    check("abort_starts", 32'(start_cnt - s0), 32'd1);

    // Backpressure: 6 pixels into a 4-deep FIFO.
    repeat (5) @(negedge clk);
    pix_ready = 1'b0;
    s0 = start_cnt;
    for (int i = 0; i < 6; i++) begin
      set_sel(0, i);
      if (i < 4) exp_q.push_back(ent(0, i));
      repeat (30) @(negedge clk);
    end
    clear_sel();
    repeat (5) @(negedge clk);
    check("bp_overflow", 32'(overflow), 32'd1);
    check("bp_valid", 32'(pix_valid), 32'd1);
    check("bp_starts", 32'(start_cnt - s0), 32'd6);
    check("bp_pending", 32'(exp_q.size()), 32'd4);
    pix_ready = 1'b1;
    wait_drain("bp_drain");
    repeat (3) @(negedge clk);
    check("bp_empty_after", 32'(pix_valid), 32'd0);

    // Illegal select, then legal capture with sticky error.
    check("sel_err_pre", 32'(sel_err), 32'd0);
    row_enable = 2'b01;
    col_enable = 10'b0000000011;
    @(negedge clk);
    check("sel_err_rise", 32'(sel_err), 32'd1);
    s0 = start_cnt;
    repeat (20) @(negedge clk);
    check("illegal_no_start", 32'(start_cnt - s0), 32'd0);
    set_sel(1, 2);
    exp_q.push_back(ent(1, 2));
    repeat (40) @(negedge clk);
    clear_sel();
    wait_drain("legal_after_err_drain");
    check("legal_after_err_starts", 32'(start_cnt - s0), 32'd1);
    check("sel_err_sticky", 32'(sel_err), 32'd1);

    // Repeat hold.
    repeat (5) @(negedge clk);
    s0 = start_cnt;
    set_sel(0, 5);
    exp_q.push_back(ent(0, 5));
    repeat (200) @(negedge clk);
    check("hold_one_conv", 32'(start_cnt - s0), 32'd1);
    clear_sel();
    repeat (3) @(negedge clk);
    set_sel(0, 5);
    exp_q.push_back(ent(0, 5));
    repeat (40) @(negedge clk);
    clear_sel();
    wait_drain("reselect_drain");
    check("reselect_conv", 32'(start_cnt - s0), 32'd2);

    // Reset during WAIT_DONE, then a stray late adc_done.
    repeat (5) @(negedge clk);
    adc_auto = 1'b0;
    s0 = start_cnt;
    set_sel(1, 1);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (adc_start) found = 1'b1;
    end
    check("rst_start_seen", 32'(found), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset_outputs");
    clear_sel();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    late_req++;
    repeat (12) @(negedge clk);
    check("late_done_ignored", 32'(pix_valid), 32'd0);
    check("late_done_no_start", 32'(start_cnt - s0), 32'd1);
    check("late_done_no_beat", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/roic_pixel_capture.md
# roic_pixel_capture

Downstream stage of the ROIC row/column traversal FSM. It watches the one-hot row/column enables and detects each newly selected pixel. After a programmable analog settle time it runs one ADC conversion handshake. Each sample is tagged with its row/column address and frame-boundary flags, then buffered in a small FIFO and presented on a valid/ready stream to the frame packer.

## Interface
- NUM_ROWS, 2, rows in the array (one-hot row_enable width)
- NUM_COLS, 10, columns in the array (one-hot col_enable width)
- DATA_W, 12, ADC sample width
- SETTLE, 8, settle cycles between pixel select and ADC start (1..255)
- FIFO_DEPTH, 4, output FIFO entries (power of two, ≥2)

- clk  in  1  single clock, all logic rising-edge
- rst_n  in  1  asynchronous, active-low reset
- row_enable  in  NUM_ROWS  one-hot row select from traversal FSM
- col_enable  in  NUM_COLS  one-hot column select from traversal FSM
- adc_start  out  1  one-cycle conversion request
- adc_done  in  1  one-cycle conversion-complete strobe
- adc_data  in  DATA_W  sample, valid when adc_done=1
- pix_valid  out  1  FIFO head valid
- pix_ready  in  1  consumer accepts head when pix_valid&pix_ready
- pix_data  out  DATA_W  sample
- pix_row  out  $clog2(NUM_ROWS)  row index
- pix_col  out  $clog2(NUM_COLS)  column index
- pix_sof  out  1  head is pixel (0,0)
- pix_eof  out  1  head is pixel (NUM_ROWS-1, NUM_COLS-1)
- overflow  out  1  sticky: sample dropped, FIFO full
- sel_err  out  1  sticky: non-one-hot enable seen

## Operation
- Select valid = both enables exactly one-hot. Both zero = idle, no error. Any other pattern (multi-hot, or only one vector nonzero) sets sel_err and is treated as no selection.
- Trigger: in IDLE, a valid select whose encoded (row,col) differs from last_addr, or any valid select after a no-selection cycle. Address is latched on trigger. last_addr resets to "none".
- FSM: IDLE -> SETTLE on trigger.
- SETTLE counts SETTLE cycles, then -> CONVERT. If the select changes or goes invalid during SETTLE -> IDLE (abort, no conversion, last_addr not updated).
- CONVERT asserts adc_start for one cycle -> WAIT_DONE.
- WAIT_DONE holds until adc_done, ignoring select changes, -> STORE.
- STORE writes {data,row,col,sof,eof} to the FIFO and updates last_addr, -> IDLE. If the FIFO is full with no simultaneous pop, the sample is dropped, overflow is set, and last_addr is still updated.
- adc_done outside WAIT_DONE is ignored.
- FIFO: simultaneous push and pop while full succeeds. Pop while empty is ignored. Stream outputs are driven from the FIFO head, and pix_data/row/col/flags hold stable while pix_valid && !pix_ready.
- Sticky flags clear only on reset.

## Timing
- Reset values: adc_start=0, pix_valid=0, pix_data=0, pix_row=0, pix_col=0, pix_sof=0, pix_eof=0, overflow=0, sel_err=0. FSM goes to IDLE, FIFO empties, counters clear.
- Reset asserted mid-conversion abandons the conversion, and a late adc_done after release is ignored.
- Trigger seen at edge T: SETTLE occupies T+1..T+SETTLE, and adc_start is high for the cycle after edge T+SETTLE.
- adc_done sampled at edge D: data is latched into STORE, FIFO write at edge D+1, and pix_valid high after edge D+2 (fixed 2-cycle latency from adc_done to stream).
- Minimum pixel period is SETTLE+4 cycles plus ADC latency.
- sel_err rises the cycle after the offending input is sampled.

## Structure
- Shared package roic_pkg holds: capture FSM state enum (IDLE, SETTLE, CONVERT, WAIT_DONE, STORE), the FIFO entry struct {data,row,col,sof,eof}, and the onehot-valid/encode function.
- Sub-module roic_capture_fifo: synchronous FIFO of pkg entry type, parameter DEPTH, with full/empty, push/pop, and a registered head.

## Test plan
- Frame sweep: traversal-style stimulus over 2x10 with a 70-cycle hold, ADC model with done 5 cycles after start -> 20 beats in order (0,0)..(1,9), sof only on the first, eof only on the last, data matches the model.
- Settle abort: select (0,3), change to (0,4) after 3 cycles with SETTLE=8 -> no adc_start for (0,3), exactly one conversion for (0,4).
- Backpressure: pix_ready=0 for a 6-pixel sweep, DEPTH=4 -> 4 beats held stable, overflow=1, pixels 5-6 lost. Release pix_ready -> 4 beats drain in order.
- Illegal select: col_enable=10'b0000000011 -> sel_err=1, no adc_start. Then legal (1,2) -> normal capture, sel_err remains 1.
- Reset mid-operation: rst_n low during WAIT_DONE -> all outputs at reset values. adc_done arriving after release -> no FIFO write.
- Repeat hold: (0,5) held 200 cycles -> exactly one conversion. Deassert then reassert (0,5) -> second conversion.
